// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and header helper for the UART tx arbiter
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] idx);
        return base | {5'b0, idx};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker, searches from ptr+1 with wrap
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int            c;
    logic [IW-1:0] ci;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        // The last candidate examined is ptr itself, so it has lowest priority.
        for (int k = 1; k <= N; k++) begin
            c  = (int'(ptr) + k) % N;
            ci = IW'(c);
            if (!found && req[ci]) begin
                found     = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter feeding one UART tx FIFO write port
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          REQ_NUM  = 4,
    parameter bit          HDR_EN   = 1'b1,
    parameter logic [7:0]  HDR_BASE = 8'hA0,
    parameter int          MAX_LEN  = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REQ_NUM-1:0]     iv_req_valid,
    input  logic [REQ_NUM-1:0]     iv_req_last,
    input  logic [8*REQ_NUM-1:0]   iv_req_data,
    output logic [REQ_NUM-1:0]     ov_req_ready,
    input  logic                   i_tx_fifo_full,
    output logic                   o_tx_fifo_wr,
    output logic [7:0]             ov_tx_fifo_din,
    output logic [REQ_NUM-1:0]     ov_grant,
    output logic                   o_busy
);

    localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [1:0]         state;
    logic [IW-1:0]      ptr;
    logic [7:0]         cnt;

    logic [REQ_NUM-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               accept;
    logic               at_max;

    uart_tx_arbiter_rr_pick #(
        .N  (REQ_NUM),
        .IW (IW)
    ) u_rr_pick (
        .req   (iv_req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (ov_grant[i]) begin
                sel_valid = iv_req_valid[i];
                sel_last  = iv_req_last[i];
                sel_data  = iv_req_data[8*i +: 8];
            end
        end
    end

    assign accept = (state == ST_DATA) && sel_valid && !i_tx_fifo_full;
    assign at_max = (cnt == 8'(MAX_LEN - 1));
    assign o_busy = (state != ST_IDLE);

    // Write and accept share one cycle: ready mirrors the FIFO's room, never buffered here.
    always_comb begin
        o_tx_fifo_wr   = 1'b0;
        ov_tx_fifo_din = '0;
        ov_req_ready   = '0;
        case (state)
            ST_HDR: begin
                o_tx_fifo_wr   = !i_tx_fifo_full;
                ov_tx_fifo_din = hdr_byte(HDR_BASE, 3'(ptr));
            end
            ST_DATA: begin
                ov_req_ready   = ov_grant & {REQ_NUM{!i_tx_fifo_full}};
                o_tx_fifo_wr   = sel_valid && !i_tx_fifo_full;
                ov_tx_fifo_din = sel_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ov_grant <= '0;
            ptr      <= IW'(REQ_NUM - 1);
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        ov_grant <= pick_grant;
                        ptr      <= pick_idx;
                        state    <= HDR_EN ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (!i_tx_fifo_full) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        // A length cut leaves the rest of the packet to be re-arbitrated with a fresh header.
                        if (sel_last || at_max) begin
                            state    <= ST_IDLE;
                            ov_grant <= '0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        fifo_full, tx_wr, busy;
    logic [7:0]  tx_din;

    logic [3:0]  v2, l2, r2, grant2;
    logic [31:0] d2;
    logic        full2, wr2, busy2;
    logic [7:0]  din2;

    int          checks, errors;
    logic [7:0]  exp_q[$];
    logic [8:0]  src_q[4][$];
    logic [3:0]  acc;

    uart_tx_arbiter #(.REQ_NUM(4), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .MAX_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .iv_req_valid(req_valid), .iv_req_last(req_last),
        .iv_req_data(req_data), .ov_req_ready(req_ready), .i_tx_fifo_full(fifo_full),
        .o_tx_fifo_wr(tx_wr), .ov_tx_fifo_din(tx_din), .ov_grant(grant), .o_busy(busy)
    );

    uart_tx_arbiter #(.REQ_NUM(4), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .MAX_LEN(255)) dut_nh (
        .clk(clk), .reset_n(reset_n), .iv_req_valid(v2), .iv_req_last(l2),
        .iv_req_data(d2), .ov_req_ready(r2), .i_tx_fifo_full(full2),
        .o_tx_fifo_wr(wr2), .ov_tx_fifo_din(din2), .ov_grant(grant2), .o_busy(busy2)
    );

    task automatic monitor_step();
        logic [7:0] e;
        checks++;
        if (((req_ready & ~grant) != 4'b0) || ($countones(req_ready) > 1)) begin
            errors++;
            $display("FAIL ready_onehot act ready=%b grant=%b req ready subset of grant, at most one", req_ready, grant);
        end
        if (tx_wr) begin
            checks++;
            if (fifo_full) begin
                errors++;
                $display("FAIL wr_while_full act wr=1 req wr=0");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write act din=%h req no write", tx_din);
            end else begin
                e = exp_q.pop_front();
                if (tx_din !== e) begin
                    errors++;
                    $display("FAIL fifo_byte act %h req %h", tx_din, e);
                end
            end
        end
    endtask

    task automatic drive_step(input logic [3:0] a);
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            if (a[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                h                  = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_last[i]        = h[8];
                req_data[8*i +: 8] = h[7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (grant !== 4'b0)     begin errors++; $display("FAIL rst_grant act %b req 0000", grant); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy act %b req 0", busy); end
        if (tx_wr !== 1'b0)     begin errors++; $display("FAIL rst_wr act %b req 0", tx_wr); end
        if (tx_din !== 8'h00)   begin errors++; $display("FAIL rst_din act %h req 00", tx_din); end
        if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready act %b req 0000", req_ready); end
        if (grant2 !== 4'b0)    begin errors++; $display("FAIL rst_grant_nh act %b req 0000", grant2); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy act %b req 0", busy); end
    endtask

    task automatic test_single();
        int nbusy, nwr;
        bit ok;
        apply_reset();
        push_exp(8'hA0); push_exp(8'h11); push_exp(8'h22); push_exp(8'h33);
        push_src(0, 8'h11, 1'b0); push_src(0, 8'h22, 1'b0); push_src(0, 8'h33, 1'b1);
        nbusy = 0; nwr = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (tx_wr) nwr++;
        end
        checks += 3;
        if (nbusy != 4) begin errors++; $display("FAIL single_busy_cycles act %0d req 4", nbusy); end
        if (nwr != 4)   begin errors++; $display("FAIL single_writes act %0d req 4", nwr); end
        wait_drain(ok);
        if (!ok) begin errors++; $display("FAIL single_drain act %0d left req 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int rs[3] = '{0, 1, 3};
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                push_exp(8'hA0 | 8'(rs[j]));
                push_exp(8'(rs[j] * 16 + k + 1));
                push_src(rs[j], 8'(rs[j] * 16 + k + 1), 1'b1);
            end
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_drain act %0d left req 0", exp_q.size()); end
    endtask

    task automatic test_full_stall();
        bit ok;
        bit seen;
        apply_reset();
        push_exp(8'hA0);
        for (int k = 1; k <= 4; k++) begin
            push_exp(8'hC0 + 8'(k));
            push_src(0, 8'hC0 + 8'(k), k == 4);
        end
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (exp_q.size() <= 3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL full_start_timeout act %0d left req <=3", exp_q.size()); end
        @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (tx_wr !== 1'b0 || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL full_stall act wr=%b ready=%b req wr=0 ready=0000", tx_wr, req_ready);
            end
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_drain act %0d left req 0", exp_q.size()); end
    endtask

    task automatic test_max_len();
        bit ok;
        bit seen;
        apply_reset();
        push_exp(8'hA2);
        for (int k = 1; k <= 4; k++) push_exp(8'h20 + 8'(k));
        push_exp(8'hA1); push_exp(8'h31); push_exp(8'h32);
        push_exp(8'hA2); push_exp(8'h25); push_exp(8'h26);
        for (int k = 1; k <= 6; k++) push_src(2, 8'h20 + 8'(k), k == 6);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (grant === 4'b0100) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL maxlen_grant2 act %b req 0100", grant); end
        push_src(1, 8'h31, 1'b0);
        push_src(1, 8'h32, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL maxlen_drain act %0d left req 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        apply_reset();
        push_exp(8'hA0); push_exp(8'hE1); push_exp(8'hE2);
        push_src(0, 8'hE1, 1'b0);
        push_src(0, 8'hE2, 1'b0);
        wait_drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL midrst_pre_drain act %0d left req 0", exp_q.size()); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL midrst_busy_pre act %b req 1", busy); end
        if (grant !== 4'b0001)  begin errors++; $display("FAIL midrst_grant_pre act %b req 0001", grant); end
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (grant !== 4'b0 || busy !== 1'b0 || tx_wr !== 1'b0 || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL midrst_hold act grant=%b busy=%b wr=%b ready=%b req all 0", grant, busy, tx_wr, req_ready);
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        push_exp(8'hA0); push_exp(8'h0F);
        push_exp(8'hA1); push_exp(8'h1F);
        push_src(1, 8'h1F, 1'b1);
        push_src(0, 8'h0F, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_post_drain act %0d left req 0", exp_q.size()); end
    endtask

    task automatic test_no_header();
        int nwr, first;
        bit wrote;
        @(posedge clk);
        #1;
        v2 = 4'b0010; l2 = 4'b0010; d2 = 32'h0000_5A00;
        nwr = 0; first = -1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            wrote = wr2;
            if (wr2) begin
                nwr++;
                if (first < 0) first = n;
                checks += 2;
                if (din2 !== 8'h5A)  begin errors++; $display("FAIL nh_din act %h req 5a", din2); end
                if (r2 !== 4'b0010)  begin errors++; $display("FAIL nh_ready act %b req 0010", r2); end
            end
            @(posedge clk);
            #1;
            if (wrote) begin v2 = 4'b0; l2 = 4'b0; d2 = 32'h0; end
        end
        checks += 2;
        if (nwr != 1)   begin errors++; $display("FAIL nh_writes act %0d req 1", nwr); end
        if (first != 1) begin errors++; $display("FAIL nh_latency act %0d req 1", first); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        v2 = '0; l2 = '0; d2 = '0; full2 = 1'b0;
        acc = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
                acc = req_valid & req_ready;
                @(posedge clk);
                #1 drive_step(acc);
            end
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_max_len();
        test_mid_reset();
        test_no_header();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue act %0d left req 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
